// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2: 16x-oversampled UART receiver with idle qualification, majority voting and a one-word output buffer.
module uart_rx_gen2 #(
  parameter int P_DATA_BITS   = 8,
  parameter int P_PARITY      = 0,
  parameter int P_STOP_BITS   = 2,
  parameter int P_REG_MODE_TH = 16
) (
  input  logic                   x16_BAUD,
  input  logic                   reset,
  input  logic                   serial_in,
  input  logic                   rd_ready,
  output logic [P_DATA_BITS-1:0] Do,
  output logic                   valid,
  output logic                   error,
  output logic                   parity_err,
  output logic                   overrun
);
  localparam int IW = $clog2(P_REG_MODE_TH + 1);
  typedef enum logic [2:0] {S_QUAL, S_ARMED, S_START, S_DATA, S_PARITY, S_STOP, S_ERROR} state_t;
  state_t                 state_q;
  logic                   sync1_q, sync2_q, s7_q, s8_q, perr_q;
  logic                   valid_q, error_q, parity_err_q, overrun_q;
  logic [IW-1:0]          idle_q;
  logic [3:0]             tick_q, bit_q;
  logic [P_DATA_BITS-1:0] shift_q, do_q;
  logic                   maj, mid, wrap, par_bad;
  always_comb begin
    maj     = (s7_q & s8_q) | (s7_q & sync2_q) | (s8_q & sync2_q);
    mid     = tick_q == 4'd9;
    wrap    = tick_q == 4'd15;
    par_bad = (maj ^ (^shift_q)) != (P_PARITY == 2);
  end
  always_ff @(posedge x16_BAUD or posedge reset)
    if (reset) begin
      state_q      <= S_QUAL;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      s7_q         <= 1'b0;
      s8_q         <= 1'b0;
      perr_q       <= 1'b0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      idle_q       <= '0;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      do_q         <= '0;
    end else begin
      sync1_q      <= serial_in;
      sync2_q      <= sync1_q;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      if (valid_q && rd_ready) valid_q <= 1'b0;
      if (tick_q == 4'd7) s7_q <= sync2_q;
      if (tick_q == 4'd8) s8_q <= sync2_q;
      if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) tick_q <= tick_q + 4'd1;
      case (state_q)
        S_QUAL: begin
          idle_q <= sync2_q ? idle_q + 1'b1 : '0;
          if (sync2_q && idle_q == IW'(P_REG_MODE_TH - 1)) begin
            state_q <= S_ARMED;
            idle_q  <= '0;
          end
        end
        S_ARMED:
          if (!sync2_q) begin
            state_q <= S_START;
            tick_q  <= '0;
            bit_q   <= '0;
            perr_q  <= 1'b0;
          end
        S_START:
          if (mid && maj) begin
            state_q <= S_ARMED;
            tick_q  <= '0;
          end else if (wrap) state_q <= S_DATA;
        S_DATA: begin
          if (mid) begin
            shift_q <= {maj, shift_q[P_DATA_BITS-1:1]};
            bit_q   <= bit_q + 4'd1;
          end
          if (wrap && bit_q == 4'(P_DATA_BITS)) begin
            bit_q   <= '0;
            state_q <= (P_PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (mid) perr_q <= par_bad;
          if (wrap) state_q <= S_STOP;
        end
        S_STOP:
          if (mid) begin
            if (!maj) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else if (bit_q == 4'(P_STOP_BITS - 1)) begin
              // Re-arm at mid stop bit so a following start edge is not missed
              state_q <= S_ARMED;
              tick_q  <= '0;
              bit_q   <= '0;
              if (perr_q) parity_err_q <= 1'b1;
              else if (!valid_q || rd_ready) begin
                do_q    <= shift_q;
                valid_q <= 1'b1;
              end else overrun_q <= 1'b1;
            end else bit_q <= bit_q + 4'd1;
          end
        default: ;
      endcase
    end
  assign Do         = do_q;
  assign valid      = valid_q;
  assign error      = error_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
endmodule
